// File: rtl/spi_slave_port.sv
// spi_slave_port: mode-0 SPI slave with an Avalon-style register port.
// SCLK, SS_n and MOSI are oversampled in the clk domain. All shifting is
// driven by edges detected on the synchronized copies, so the design has a
// single clock domain.
module spi_slave_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam logic [2:0]  ADDR_RXDATA  = 3'd0;
    localparam logic [2:0]  ADDR_TXDATA  = 3'd1;
    localparam logic [2:0]  ADDR_STATUS  = 3'd2;
    localparam logic [2:0]  ADDR_CONTROL = 3'd3;
    localparam logic [15:0] CONTROL_MASK = 16'h01D8;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic        sclk_s, ss_s, mosi_s, sclk_d, ss_d;
    logic        ss_active, sclk_rise, sclk_fall, ss_start, byte_done, tx_load;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_hold, tx_shift, tx_hold;
    logic        tx_primed, rrdy, roe, toe, tur, error, trdy;
    logic        rd_strobe, wr_strobe, p1_rd_strobe, p1_wr_strobe;
    logic        rd_rxdata, wr_txdata, wr_status, wr_control;
    logic [15:0] control_reg, status_word, read_mux;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronizer chains; SS_n idles high so reset leaves the slave deselected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign ss_active = ~ss_s;
    assign sclk_rise = ss_active & sclk_s & ~sclk_d;
    assign sclk_fall = ss_active & ~sclk_s & sclk_d;
    assign ss_start  = ss_d & ~ss_s;
    assign byte_done = sclk_rise & (bit_cnt == 3'd7);
    assign tx_load   = ss_start | byte_done;

    // Two-cycle bus strobes: effects land on the registered strobe.
    assign p1_rd_strobe = ~rd_strobe & spi_select & ~read_n;
    assign p1_wr_strobe = ~wr_strobe & spi_select & ~write_n;
    assign rd_rxdata    = rd_strobe & (mem_addr == ADDR_RXDATA);
    assign wr_txdata    = wr_strobe & (mem_addr == ADDR_TXDATA);
    assign wr_status    = wr_strobe & (mem_addr == ADDR_STATUS);
    assign wr_control   = wr_strobe & (mem_addr == ADDR_CONTROL);

    // Strobe registers that stretch each access into a two-cycle event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            rd_strobe <= p1_rd_strobe;
            wr_strobe <= p1_wr_strobe;
        end
    end

    // Bit counter and shift registers; a deselect mid-byte drops the partial byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            rx_hold  <= 8'h00;
            tx_shift <= 8'h00;
        end else begin
            if (!ss_active)
                bit_cnt <= 3'd0;
            else if (sclk_rise)
                bit_cnt <= bit_cnt + 3'd1;
            if (sclk_rise)
                rx_shift <= {rx_shift[5:0], mosi_s};
            if (byte_done)
                rx_hold <= {rx_shift, mosi_s};
            if (tx_load)
                tx_shift <= tx_primed ? tx_hold : 8'h00;
            else if (sclk_fall && bit_cnt != 3'd0)
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // Flags and TX holding register; pin-side set events win over bus clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            tur         <= 1'b0;
            tx_primed   <= 1'b0;
            tx_hold     <= 8'h00;
            control_reg <= 16'h0000;
        end else begin
            if (byte_done)
                rrdy <= 1'b1;
            else if (rd_rxdata)
                rrdy <= 1'b0;
            if (byte_done && rrdy && !rd_rxdata)
                roe <= 1'b1;
            else if (wr_status)
                roe <= 1'b0;
            if (tx_load && !tx_primed)
                tur <= 1'b1;
            else if (wr_status)
                tur <= 1'b0;
            if (wr_txdata && tx_primed)
                toe <= 1'b1;
            else if (wr_status)
                toe <= 1'b0;
            if (wr_txdata && !tx_primed) begin
                tx_hold   <= data_from_cpu[7:0];
                tx_primed <= 1'b1;
            end else if (tx_load) begin
                tx_primed <= 1'b0;
            end
            if (wr_control)
                control_reg <= data_from_cpu & CONTROL_MASK;
        end
    end

    assign error       = roe | toe | tur;
    assign trdy        = ~tx_primed;
    assign status_word = {7'd0, error, rrdy, trdy, ss_active, toe, roe, tur, 2'b00};

    // Read data selection by register address.
    always_comb begin
        read_mux = 16'h0000;
        case (mem_addr)
            ADDR_RXDATA:  read_mux = {8'h00, rx_hold};
            ADDR_STATUS:  read_mux = status_word;
            ADDR_CONTROL: read_mux = control_reg;
            default:      read_mux = 16'h0000;
        endcase
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            data_to_cpu <= read_mux;
            irq         <= (error & control_reg[8]) | (rrdy & control_reg[7]) |
                           (trdy & control_reg[6]) | (toe & control_reg[4]) |
                           (roe & control_reg[3]);
        end
    end

    assign MISO_oe       = ss_active;
    assign MISO          = ss_active & tx_shift[7];
    assign dataavailable = rrdy;
    assign readyfordata  = trdy;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: drives a mode-0 SPI master and the register port with
// randomized bytes, and predicts every observable from a byte-level model.
module tb_spi_slave_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        irq, dataavailable, readyfordata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] miso;
        logic [7:0] exp_miso;
        logic       rrdy2;
        logic       exp_rrdy2;
        logic       rrdy3;
        logic       irq3;
        logic       exp_irq3;
        logic       irq4;
        logic       exp_irq4;
    } xfer_t;

    // Byte-level reference model state.
    logic [7:0]  m_hold, m_rx, m_out;
    logic [15:0] m_ctrl;
    bit          m_primed, m_rrdy, m_roe, m_toe, m_tur, m_ss;

    spi_slave_port #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
        .dataavailable(dataavailable), .readyfordata(readyfordata)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void model_reset();
        m_hold = 8'h00; m_rx = 8'h00; m_out = 8'h00; m_ctrl = 16'h0000;
        m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_ss = 0;
    endfunction

    function automatic logic [7:0] model_load();
        if (m_primed) begin
            m_primed = 0;
            return m_hold;
        end
        m_tur = 1;
        return 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] rx);
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1;
        m_rx   = rx;
        m_out  = model_load();
    endfunction

    function automatic logic [15:0] model_status();
        logic [15:0] v = 16'h0000;
        if (m_roe || m_toe || m_tur) v = v + 16'd256;
        if (m_rrdy)   v = v + 16'd128;
        if (!m_primed) v = v + 16'd64;
        if (m_ss)     v = v + 16'd32;
        if (m_toe)    v = v + 16'd16;
        if (m_roe)    v = v + 16'd8;
        if (m_tur)    v = v + 16'd4;
        return v;
    endfunction

    function automatic logic model_irq();
        bit e = m_roe || m_toe || m_tur;
        return (e && m_ctrl[8]) || (m_rrdy && m_ctrl[7]) || (!m_primed && m_ctrl[6]) ||
               (m_toe && m_ctrl[4]) || (m_roe && m_ctrl[3]);
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
        case (a)
            3'd1: if (!m_primed) begin m_hold = d[7:0]; m_primed = 1; end else m_toe = 1;
            3'd2: begin m_roe = 0; m_toe = 0; m_tur = 0; end
            3'd3: m_ctrl = d & 16'h01D8;
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: begin m_rrdy = 0; return {8'h00, m_rx}; end
            3'd2: return model_status();
            3'd3: return m_ctrl;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
        repeat (2) @(negedge clk);
        spi_select = 0; write_n = 1;
        model_write(a, d);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] obs, output logic [15:0] exp);
        @(negedge clk);
        spi_select = 1; read_n = 0; mem_addr = a;
        @(negedge clk);
        obs = data_to_cpu;
        exp = model_read(a);
        @(negedge clk);
        spi_select = 0; read_n = 1;
    endtask

    task automatic spi_begin();
        SS_n = 0; SCLK = 0;
        repeat (5) @(negedge clk);
        m_ss  = 1;
        m_out = model_load();
    endtask

    task automatic spi_end();
        repeat (5) @(negedge clk);
        SS_n = 1;
        repeat (5) @(negedge clk);
        m_ss = 0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output xfer_t r);
        r.exp_miso = m_out;
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (5) @(negedge clk);
            r.miso[i] = MISO;
            SCLK = 1;
            if (i == 0) begin
                repeat (2) @(negedge clk);
                r.rrdy2 = dataavailable; r.exp_rrdy2 = m_rrdy;
                @(negedge clk);
                r.rrdy3 = dataavailable; r.irq3 = irq; r.exp_irq3 = model_irq();
                model_byte(tx);
                @(negedge clk);
                r.irq4 = irq; r.exp_irq4 = model_irq();
                @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            SCLK = 0;
        end
    endtask

    task automatic spi_partial(input int n, output logic [7:0] bits);
        bits = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = 1'($urandom_range(1));
            repeat (5) @(negedge clk);
            bits[i] = MISO;
            SCLK = 1;
            repeat (5) @(negedge clk);
            SCLK = 0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] o, e;
        reset_n = 0; SS_n = 1; SCLK = 0; MOSI = 0; spi_select = 0;
        read_n = 1; write_n = 1; mem_addr = 3'd0; data_from_cpu = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", MISO_oe); end
        checks++; if (data_to_cpu !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", data_to_cpu); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (dataavailable !== 1'b0) begin errors++; $display("[TB] FAIL reset_rrdy: got %b expected 0", dataavailable); end
        checks++; if (readyfordata !== 1'b1) begin errors++; $display("[TB] FAIL reset_trdy: got %b expected 1", readyfordata); end
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", o, e); end
        cpu_read(3'd3, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL reset_control: got %h expected %h", o, e); end
    endtask

    task automatic test_single_byte();
        xfer_t r;
        logic [7:0] tx, rx;
        logic [15:0] o, e;
        for (int k = 0; k < 4; k++) begin
            tx = (k == 0) ? 8'hA5 : 8'($urandom);
            rx = (k == 0) ? 8'h3C : 8'($urandom);
            cpu_write(3'd1, {8'h00, tx});
            @(negedge clk);
            checks++; if (readyfordata !== !m_primed) begin errors++; $display("[TB] FAIL single_trdy_primed: got %b expected %b", readyfordata, !m_primed); end
            spi_begin();
            checks++; if (readyfordata !== !m_primed) begin errors++; $display("[TB] FAIL single_trdy_loaded: got %b expected %b", readyfordata, !m_primed); end
            spi_byte(rx, r);
            spi_end();
            checks++; if (r.miso !== r.exp_miso) begin errors++; $display("[TB] FAIL single_miso: got %h expected %h", r.miso, r.exp_miso); end
            checks++; if (r.rrdy2 !== r.exp_rrdy2) begin errors++; $display("[TB] FAIL single_rrdy_early: got %b expected %b", r.rrdy2, r.exp_rrdy2); end
            checks++; if (r.rrdy3 !== 1'b1) begin errors++; $display("[TB] FAIL single_rrdy_latency: got %b expected 1", r.rrdy3); end
            checks++; if (r.irq4 !== r.exp_irq4) begin errors++; $display("[TB] FAIL single_irq: got %b expected %b", r.irq4, r.exp_irq4); end
            cpu_read(3'd0, o, e);
            checks++; if (o !== e) begin errors++; $display("[TB] FAIL single_rxdata: got %h expected %h", o, e); end
            cpu_read(3'd2, o, e);
            checks++; if (o !== e) begin errors++; $display("[TB] FAIL single_status: got %h expected %h", o, e); end
            cpu_write(3'd2, 16'h0000);
        end
    endtask

    task automatic test_underrun();
        xfer_t r0, r1;
        logic [7:0] b0, b1;
        logic [15:0] o, e;
        b0 = 8'($urandom); b1 = 8'($urandom);
        spi_begin();
        spi_byte(b0, r0);
        spi_byte(b1, r1);
        spi_end();
        checks++; if (r0.miso !== r0.exp_miso) begin errors++; $display("[TB] FAIL underrun_miso0: got %h expected %h", r0.miso, r0.exp_miso); end
        checks++; if (r1.miso !== r1.exp_miso) begin errors++; $display("[TB] FAIL underrun_miso1: got %h expected %h", r1.miso, r1.exp_miso); end
        checks++; if (r1.rrdy2 !== r1.exp_rrdy2) begin errors++; $display("[TB] FAIL underrun_rrdy_held: got %b expected %b", r1.rrdy2, r1.exp_rrdy2); end
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL underrun_status: got %h expected %h", o, e); end
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL underrun_rxdata: got %h expected %h", o, e); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL underrun_cleared: got %h expected %h", o, e); end
    endtask

    task automatic test_tx_overrun();
        xfer_t r;
        logic [7:0] t1, t2;
        logic [15:0] o, e;
        t1 = 8'($urandom); t2 = ~t1;
        cpu_write(3'd1, {8'h00, t1});
        cpu_write(3'd1, {8'h00, t2});
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL overrun_status: got %h expected %h", o, e); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL overrun_cleared: got %h expected %h", o, e); end
        spi_begin();
        spi_byte(8'($urandom), r);
        spi_end();
        checks++; if (r.miso !== r.exp_miso) begin errors++; $display("[TB] FAIL overrun_miso: got %h expected %h", r.miso, r.exp_miso); end
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL overrun_rxdata: got %h expected %h", o, e); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_abort();
        xfer_t r;
        logic [7:0] a, bits, exp_bits, c;
        logic [15:0] o, e;
        a = 8'($urandom);
        cpu_write(3'd1, {8'h00, a});
        spi_begin();
        exp_bits = m_out & 8'hF8;
        spi_partial(5, bits);
        spi_end();
        checks++; if (bits !== exp_bits) begin errors++; $display("[TB] FAIL abort_miso: got %h expected %h", bits, exp_bits); end
        checks++; if (dataavailable !== m_rrdy) begin errors++; $display("[TB] FAIL abort_no_rrdy: got %b expected %b", dataavailable, m_rrdy); end
        cpu_write(3'd1, {8'h00, ~a});
        c = 8'($urandom);
        spi_begin();
        spi_byte(c, r);
        spi_end();
        checks++; if (r.miso !== r.exp_miso) begin errors++; $display("[TB] FAIL abort_next_miso: got %h expected %h", r.miso, r.exp_miso); end
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL abort_next_rxdata: got %h expected %h", o, e); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_irq();
        xfer_t r;
        logic [15:0] o, e;
        logic irq_before;
        cpu_write(3'd3, 16'h0080);
        cpu_write(3'd1, 16'($urandom));
        repeat (2) @(negedge clk);
        checks++; if (irq !== model_irq()) begin errors++; $display("[TB] FAIL irq_idle: got %b expected %b", irq, model_irq()); end
        spi_begin();
        spi_byte(8'($urandom), r);
        spi_end();
        checks++; if (r.irq3 !== r.exp_irq3) begin errors++; $display("[TB] FAIL irq_lag: got %b expected %b", r.irq3, r.exp_irq3); end
        checks++; if (r.irq4 !== r.exp_irq4) begin errors++; $display("[TB] FAIL irq_set: got %b expected %b", r.irq4, r.exp_irq4); end
        irq_before = model_irq();
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL irq_rxdata: got %h expected %h", o, e); end
        checks++; if (dataavailable !== m_rrdy) begin errors++; $display("[TB] FAIL irq_rrdy_clear: got %b expected %b", dataavailable, m_rrdy); end
        checks++; if (irq !== irq_before) begin errors++; $display("[TB] FAIL irq_clear_lag: got %b expected %b", irq, irq_before); end
        @(negedge clk);
        checks++; if (irq !== model_irq()) begin errors++; $display("[TB] FAIL irq_cleared: got %b expected %b", irq, model_irq()); end
        cpu_write(3'd3, 16'h0000);
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_back_to_back();
        xfer_t r;
        logic [15:0] o, e;
        spi_begin();
        for (int n = 0; n < 4; n++) begin
            fork
                spi_byte(8'($urandom), r);
                begin
                    repeat (3) @(negedge clk);
                    if ($urandom_range(1) == 1) cpu_write(3'd1, 16'($urandom));
                    cpu_read(3'd0, o, e);
                end
            join
            checks++; if (r.miso !== r.exp_miso) begin errors++; $display("[TB] FAIL b2b_miso%0d: got %h expected %h", n, r.miso, r.exp_miso); end
            checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_rxdata%0d: got %h expected %h", n, o, e); end
        end
        spi_end();
        cpu_read(3'd2, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_status: got %h expected %h", o, e); end
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_last_rx: got %h expected %h", o, e); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_reset_midbyte();
        xfer_t r;
        logic [7:0] bits;
        logic [15:0] o, e;
        cpu_write(3'd3, 16'h0100);
        spi_begin();
        cpu_write(3'd1, 16'($urandom));
        mem_addr = 3'd2;
        spi_partial(3, bits);
        checks++; if (irq !== model_irq()) begin errors++; $display("[TB] FAIL midreset_pre_irq: got %b expected %b", irq, model_irq()); end
        checks++; if (MISO_oe !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_oe: got %b expected 1", MISO_oe); end
        reset_n = 0;
        #1;
        checks++; if (MISO !== 1'b0) begin errors++; $display("[TB] FAIL midreset_miso: got %b expected 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("[TB] FAIL midreset_oe: got %b expected 0", MISO_oe); end
        checks++; if (data_to_cpu !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 0000", data_to_cpu); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq); end
        checks++; if (dataavailable !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rrdy: got %b expected 0", dataavailable); end
        checks++; if (readyfordata !== 1'b1) begin errors++; $display("[TB] FAIL midreset_trdy: got %b expected 1", readyfordata); end
        SS_n = 1; SCLK = 0; MOSI = 0; mem_addr = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;
        cpu_write(3'd1, 16'($urandom));
        spi_begin();
        spi_byte(8'($urandom), r);
        spi_end();
        checks++; if (r.miso !== r.exp_miso) begin errors++; $display("[TB] FAIL midreset_next_miso: got %h expected %h", r.miso, r.exp_miso); end
        cpu_read(3'd0, o, e);
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL midreset_next_rx: got %h expected %h", o, e); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_byte();
        test_underrun();
        test_tx_overrun();
        test_abort();
        test_irq();
        test_back_to_back();
        test_reset_midbyte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
